// File: rtl/conv_output_packer.sv
// conv_output_packer: writes a conv result stream into the next layer's input buffer,
// surrounded by a PAD-wide border of PAD_VALUE, then pulses next_start.
module conv_output_packer #(
    parameter int          CHANNELS   = 32,
    parameter int          OUT_WIDTH  = 28,
    parameter int          OUT_HEIGHT = 28,
    parameter int          PAD        = 1,
    parameter logic [7:0]  PAD_VALUE  = 8'd0,
    localparam int         PW         = OUT_WIDTH + 2 * PAD,
    localparam int         PH         = OUT_HEIGHT + 2 * PAD,
    localparam int         DEPTH      = CHANNELS * PH * PW,
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          frame_start,
    output logic          stream_ready,
    input  logic [7:0]    conv_result,
    input  logic          conv_valid,
    output logic [7:0]    wr_data,
    output logic          wr_we,
    output logic [AW-1:0] wr_addr,
    output logic          next_start,
    output logic          done,
    output logic          busy,
    output logic          overflow_err
);
    typedef enum logic [1:0] {IDLE, FILL, STREAM, KICK} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] X_LAST    = AW'(OUT_WIDTH - 1);
    localparam logic [AW-1:0] Y_LAST    = AW'(OUT_HEIGHT - 1);
    localparam logic [AW-1:0] C_LAST    = AW'(CHANNELS - 1);
    localparam logic [AW-1:0] ROW_STEP  = AW'(PW);
    localparam logic [AW-1:0] CH_STEP   = AW'(PW * (2 * PAD + 1));
    localparam logic [AW-1:0] FIRST_ROW = AW'(PAD * PW + PAD);

    state_t        state;
    logic [AW-1:0] fill_cnt, x, y, c, row_base;
    logic          fin;
    logic          x_wrap, y_wrap, c_wrap;

    assign x_wrap       = x == X_LAST;
    assign y_wrap       = y == Y_LAST;
    assign c_wrap       = c == C_LAST;
    // fin marks the cycle the final write is on the bus; KICK follows it
    assign stream_ready = state == STREAM && !fin;
    assign busy         = state != IDLE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            fill_cnt     <= '0;
            x            <= '0;
            y            <= '0;
            c            <= '0;
            row_base     <= '0;
            fin          <= 1'b0;
            wr_we        <= 1'b0;
            wr_data      <= '0;
            wr_addr      <= '0;
            next_start   <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            wr_we      <= 1'b0;
            next_start <= 1'b0;
            done       <= 1'b0;
            if (conv_valid && state != STREAM)
                overflow_err <= 1'b1;
            else if (state == IDLE && frame_start)
                overflow_err <= 1'b0;
            case (state)
                IDLE: if (frame_start) begin
                    state    <= PAD == 0 ? STREAM : FILL;
                    fill_cnt <= '0;
                    row_base <= FIRST_ROW;
                    x        <= '0;
                    y        <= '0;
                    c        <= '0;
                    fin      <= 1'b0;
                end
                FILL: begin
                    wr_we    <= 1'b1;
                    wr_data  <= PAD_VALUE;
                    wr_addr  <= fill_cnt;
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == LAST_ADDR) state <= STREAM;
                end
                STREAM: if (fin) begin
                    state      <= KICK;
                    next_start <= 1'b1;
                    done       <= 1'b1;
                end else if (conv_valid) begin
                    wr_we   <= 1'b1;
                    wr_data <= conv_result;
                    wr_addr <= row_base + x;
                    x       <= x_wrap ? '0 : x + 1'b1;
                    if (x_wrap) begin
                        y        <= y_wrap ? '0 : y + 1'b1;
                        c        <= y_wrap ? c + 1'b1 : c;
                        row_base <= row_base + (y_wrap ? CH_STEP : ROW_STEP);
                    end
                    if (x_wrap && y_wrap && c_wrap) fin <= 1'b1;
                end
                KICK: begin
                    state    <= IDLE;
                    fill_cnt <= '0;
                    x        <= '0;
                    y        <= '0;
                    c        <= '0;
                    row_base <= '0;
                    fin      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_output_packer.sv
// tb_conv_output_packer: randomized scoreboard bench for a small padded config
// and the unpadded default config.
module tb_conv_output_packer;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic       fs, cv, sr, we, ns, dn, bz, ov;
    logic [7:0] cr, wd;
    logic [4:0] wa;
    logic        fs0, cv0, sr0, we0, ns0, dn0, bz0, ov0;
    logic [7:0]  cr0, wd0;
    logic [14:0] wa0;

    conv_output_packer #(.CHANNELS(2), .OUT_WIDTH(2), .OUT_HEIGHT(2), .PAD(1), .PAD_VALUE(8'd0)) dut (
        .clk(clk), .rstn(rstn), .frame_start(fs), .stream_ready(sr), .conv_result(cr),
        .conv_valid(cv), .wr_data(wd), .wr_we(we), .wr_addr(wa), .next_start(ns),
        .done(dn), .busy(bz), .overflow_err(ov));

    conv_output_packer #(.PAD(0)) dut0 (
        .clk(clk), .rstn(rstn), .frame_start(fs0), .stream_ready(sr0), .conv_result(cr0),
        .conv_valid(cv0), .wr_data(wd0), .wr_we(we0), .wr_addr(wa0), .next_start(ns0),
        .done(dn0), .busy(bz0), .overflow_err(ov0));

    int vectors = 0, miscompares = 0;
    int kicks = 0, kicks0 = 0, exp_kicks = 0;
    longint q[$], q0[$];

    task automatic chk(input string n, input longint a, input longint e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // scoreboards: every write and every kick is checked against the queued model
    always @(negedge clk) if (rstn) begin
        if (we) begin
            if (q.size() == 0) chk("wr_unexpected", {wa, wd}, -1);
            else chk("wr", {wa, wd}, q.pop_front());
        end
        if (ns) begin
            kicks++;
            chk("kick_done", dn, 1);
            chk("kick_drained", q.size(), 0);
        end
    end

    always @(negedge clk) if (rstn) begin
        if (we0) begin
            if (q0.size() == 0) chk("wr0_unexpected", {wa0, wd0}, -1);
            else chk("wr0", {wa0, wd0}, q0.pop_front());
        end
        if (ns0) begin
            kicks0++;
            chk("kick0_done", dn0, 1);
            chk("kick0_drained", q0.size(), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        int n;
        fs = 1'b1;
        for (int a = 0; a < 32; a++) q.push_back(longint'(a) * 256);
        tick();
        fs = 1'b0;
        n = 1;
        while (!sr && n < 100) begin
            tick();
            n++;
        end
        chk("fill_cycles", n, 33);
    endtask

    task automatic send_frame(input int gmax, input bit fixed);
        int ch, row, col;
        logic [7:0] d;
        chk("stream_ready", sr, 1);
        for (int k = 0; k < 8; k++) begin
            if (gmax > 0) repeat ($urandom_range(1, gmax)) tick();
            d   = fixed ? 8'(11 + k) : 8'($urandom);
            ch  = k / 4;
            row = (k / 2) % 2;
            col = k % 2;
            q.push_back(longint'(ch * 16 + (row + 1) * 4 + col + 1) * 256 + d);
            cv = 1'b1;
            cr = d;
            tick();
            cv = 1'b0;
        end
        exp_kicks++;
        chk("last_write", we, 1);
        tick();
        chk("next_start", ns, 1);
        chk("kick_busy", bz, 1);
        chk("kick_we", we, 0);
        tick();
        chk("next_start_pulse", ns, 0);
        chk("idle_busy", bz, 0);
    endtask

    initial begin
        int n;
        logic [7:0] d;
        rstn = 1'b0;
        {fs, cv, fs0, cv0} = '0;
        cr = '0;
        cr0 = '0;
        repeat (3) tick();
        chk("rst_outs", {sr, we, wa, wd, ns, dn, bz, ov}, 0);
        chk("rst_outs0", {sr0, we0, wa0, wd0, ns0, dn0, bz0, ov0}, 0);
        rstn = 1'b1;
        tick();

        // reset while the border fill is at address 10
        fs = 1'b1;
        for (int a = 0; a < 32; a++) q.push_back(longint'(a) * 256);
        tick();
        fs = 1'b0;
        n = 0;
        while (!(we && wa == 5'd10) && n < 50) begin
            tick();
            n++;
        end
        chk("reached_addr10", {we, wa}, {1'b1, 5'd10});
        rstn = 1'b0;
        q.delete();
        #1;
        chk("async_rst_busy", bz, 0);
        tick();
        chk("rst_mid_fill", {sr, we, wa, wd, ns, dn, bz, ov}, 0);
        rstn = 1'b1;
        tick();

        start_frame();
        send_frame(0, 1'b1);
        start_frame();
        send_frame(3, 1'b1);

        // stray conv_valid while filling is dropped and flagged
        fs = 1'b1;
        for (int a = 0; a < 32; a++) q.push_back(longint'(a) * 256);
        tick();
        fs = 1'b0;
        repeat (3) tick();
        cv = 1'b1;
        cr = 8'hAA;
        tick();
        cv = 1'b0;
        chk("overflow_set", ov, 1);
        n = 0;
        while (!sr && n < 100) begin
            tick();
            n++;
        end
        send_frame(2, 1'b0);
        chk("overflow_sticky", ov, 1);
        start_frame();
        chk("overflow_cleared", ov, 0);
        send_frame(1, 1'b0);
        start_frame();
        send_frame(0, 1'b0);

        // unpadded default geometry: no fill, dense addresses
        fs0 = 1'b1;
        tick();
        fs0 = 1'b0;
        chk("p0_ready", sr0, 1);
        for (int k = 0; k < 25088; k++) begin
            d = 8'($urandom);
            q0.push_back(longint'(k) * 256 + d);
            cv0 = 1'b1;
            cr0 = d;
            tick();
        end
        cv0 = 1'b0;
        tick();
        chk("p0_next_start", ns0, 1);
        tick();
        chk("p0_idle", bz0, 0);

        repeat (3) tick();
        chk("kicks", kicks, exp_kicks);
        chk("kicks0", kicks0, 1);
        chk("queue_empty", q.size(), 0);
        chk("queue0_empty", q0.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
